flaf_trig_expand_ctrl: RTL and testbench

Scheduler that time-shares one pipelined cosine unit to build the trigonometric functional expansion of one input sample. Expansion vector: [x, sin(pi·x), cos(pi·x), …, sin(P·pi·x), cos(P·pi·x)], with sin(t) issued as cos(t − pi/2). Sits between the input sample stream and the FLAF weight/filter stage. Issues angles to the shared cosine unit, collects tagged results into a buffer, then streams the 2P+1 words out under valid/ready.

---
 rtl/flaf_trig_expand_ctrl_pkg.sv | 25 ++
 rtl/flaf_theta_gen.sv | 45 ++++
 rtl/flaf_trig_expand_ctrl.sv | 138 +++++++++++++
 tb/tb_flaf_trig_expand_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flaf_trig_expand_ctrl_pkg.sv
// Shared Q4.12 angle constants, controller state encoding and the input clamp helper
// used when FLAF_X_SATURATE_EN is defined.
package flaf_trig_expand_ctrl_pkg;

  localparam logic signed [15:0] PI_Q12   = 16'sh3244;
  localparam logic signed [16:0] PIB2_Q12 = 17'sh01922;
  localparam logic signed [15:0] ONE_Q12  = 16'sh1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  function automatic logic signed [15:0] sat_q12(input logic signed [15:0] x);
    if (x > ONE_Q12)
      return ONE_Q12;
    else if (x < -ONE_Q12)
      return -ONE_Q12;
    return x;
  endfunction

endpackage

// File: rtl/flaf_theta_gen.sv
// Angle generator: registers theta1 = (x*PI)>>>12 on load, then accumulates k*theta1;
// theta presents the sin argument (acc - PI/2) when sub=0 and the cos argument when sub=1.
module flaf_theta_gen
  import flaf_trig_expand_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               sub,
  input  logic signed [15:0] x,
  output logic signed [16:0] theta
);

  logic signed [31:0] x_w;
  logic signed [31:0] pi_w;
  logic signed [31:0] prod;
  logic signed [16:0] theta1_n;
  logic signed [16:0] theta1;
  logic signed [16:0] acc;
  logic               unused_prod_bits;

  assign x_w  = 32'(x);
  assign pi_w = 32'(PI_Q12);
  assign prod = x_w * pi_w;

  // Bits [28:12] are the arithmetic shift by 12 truncated to 17b signed.
  assign theta1_n         = prod[28:12];
  assign unused_prod_bits = ^{prod[31:29], prod[11:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      theta1 <= '0;
      acc    <= '0;
    end else if (load) begin
      theta1 <= theta1_n;
      acc    <= theta1_n;
    end else if (step) begin
      acc <= acc + theta1;
    end
  end

  assign theta = sub ? acc : (acc - PIB2_Q12);

endmodule

// File: rtl/flaf_trig_expand_ctrl.sv
// Time-shares one cosine unit to build [x, sin(k*pi*x), cos(k*pi*x)] k=1..ORDER; first word
// 2*ORDER+CU_LAT+1 cycles after accept, held while fe_ready is low. Clamp via FLAF_X_SATURATE_EN.
module flaf_trig_expand_ctrl
  import flaf_trig_expand_ctrl_pkg::*;
#(
  parameter int ORDER  = 3,
  parameter int CU_LAT = 2,
  parameter int NW     = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] x_in,
  input  logic               x_valid,
  output logic               x_ready,
  output logic        [16:0] cu_theta,
  output logic               cu_issue,
  input  logic        [15:0] cu_cos,
  output logic        [15:0] fe_data,
  output logic        [2:0]  fe_idx,
  output logic               fe_valid,
  output logic               fe_last,
  input  logic               fe_ready,
  output logic               busy
);

  localparam logic [2:0]        LAST_TAG   = 3'(2 * ORDER);
  localparam logic [2:0]        LAST_IDX   = 3'(NW - 1);
  localparam logic [CU_LAT-1:0] LAST_STAGE = CU_LAT'(1) << (CU_LAT - 1);

  state_t             state;
  logic [2:0]         tag;
  logic [15:0]        wbuf [NW];
  logic [CU_LAT-1:0]  pv;
  logic [2:0]         pt [CU_LAT];
  logic signed [15:0] x_lat;
  logic signed [16:0] theta;
  logic               accept;
  logic               drain_done;

`ifdef FLAF_X_SATURATE_EN
  assign x_lat = sat_q12(x_in);
`else
  assign x_lat = x_in;
`endif

  assign accept  = (state == IDLE) && x_valid;
  assign x_ready = (state == IDLE);
  assign busy    = (state != IDLE);

  // Leave DRAIN once only the final stage still holds a result: it lands on the same edge.
  assign drain_done = ((pv & ~LAST_STAGE) == '0);

  flaf_theta_gen u_theta_gen (
    .clk   (clk),
    .reset (reset),
    .load  (state == MULT),
    .step  (cu_issue && !tag[0]),
    .sub   (!tag[0]),
    .x     ($signed(wbuf[0])),
    .theta (theta)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tag      <= '0;
      cu_issue <= 1'b0;
      fe_valid <= 1'b0;
      fe_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (x_valid)
            state <= MULT;
        end
        MULT: begin
          state    <= ISSUE;
          cu_issue <= 1'b1;
          tag      <= 3'd1;
        end
        ISSUE: begin
          if (tag == LAST_TAG) begin
            cu_issue <= 1'b0;
            state    <= DRAIN;
          end else begin
            tag <= tag + 3'd1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state    <= OUT;
            fe_valid <= 1'b1;
            fe_idx   <= '0;
          end
        end
        OUT: begin
          if (fe_ready) begin
            if (fe_idx == LAST_IDX) begin
              state    <= IDLE;
              fe_valid <= 1'b0;
              fe_idx   <= '0;
            end else begin
              fe_idx <= fe_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline tracks which buffer slot each in-flight cosine result belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      for (int i = 0; i < CU_LAT; i++)
        pt[i] <= '0;
      for (int i = 0; i < NW; i++)
        wbuf[i] <= '0;
    end else begin
      pv[0] <= cu_issue;
      pt[0] <= tag;
      for (int i = 1; i < CU_LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
      if (pv[CU_LAT-1])
        wbuf[pt[CU_LAT-1]] <= cu_cos;
      if (accept)
        wbuf[0] <= x_lat;
    end
  end

  assign cu_theta = cu_issue ? theta : '0;
  assign fe_data  = fe_valid ? wbuf[fe_idx] : '0;
  assign fe_last  = fe_valid && (fe_idx == LAST_IDX);

endmodule

// File: tb/tb_flaf_trig_expand_ctrl.sv
// Bench for flaf_trig_expand_ctrl: ideal cosine unit, cycle-level timing model, directed samples.
module tb_flaf_trig_expand_ctrl;

  localparam int ORDER     = 3;
  localparam int CU_LAT    = 2;
  localparam int NW        = 7;
  localparam int FIRST_OUT = 2 * ORDER + CU_LAT + 1;

  logic               clk;
  logic               reset;
  logic signed [15:0] x_in;
  logic               x_valid;
  logic               x_ready;
  logic        [16:0] cu_theta;
  logic               cu_issue;
  logic        [15:0] cu_cos;
  logic        [15:0] fe_data;
  logic        [2:0]  fe_idx;
  logic               fe_valid;
  logic               fe_last;
  logic               fe_ready;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  flaf_trig_expand_ctrl #(.ORDER(ORDER), .CU_LAT(CU_LAT), .NW(NW)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .cu_theta(cu_theta), .cu_issue(cu_issue), .cu_cos(cu_cos),
    .fe_data(fe_data), .fe_idx(fe_idx), .fe_valid(fe_valid), .fe_last(fe_last),
    .fe_ready(fe_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_vec++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  function automatic logic signed [15:0] cosq(input logic [16:0] th);
    real a, c;
    int  r;
    a = $itor($signed(th)) / 4096.0;
    c = $cos(a) * 32768.0;
    r = (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  // Ideal cosine unit with CU_LAT cycles of latency.
  logic signed [15:0] cu_pipe [CU_LAT];
  always @(posedge clk) begin
    cu_pipe[0] <= cosq(cu_theta);
    for (int i = 1; i < CU_LAT; i++)
      cu_pipe[i] <= cu_pipe[i-1];
  end
  assign cu_cos = cu_pipe[CU_LAT-1];

  // Reference model: expected words/angles from the expansion definition, timing as cycle counts.
  bit                 m_busy;
  int                 m_cyc;
  int                 m_idx;
  logic        [16:0] m_theta [2*ORDER];
  logic signed [15:0] m_word  [NW];
  int                 got [NW];
  int                 hs_cnt = 0;
  int                 hs_exp;
  int                 th_log [256];
  int                 th_n = 0;

  task automatic model_load(input logic signed [15:0] x);
    logic signed [15:0] xs;
    logic signed [16:0] t1;
    int p;
    xs = x;
`ifdef FLAF_X_SATURATE_EN
    if (xs > 16'sh1000) xs = 16'sh1000;
    else if (xs < -16'sh1000) xs = -16'sh1000;
`endif
    p  = int'(xs) * 32'sh3244;
    t1 = 17'(p >>> 12);
    m_word[0] = xs;
    for (int k = 1; k <= ORDER; k++) begin
      m_theta[2*k-2] = 17'(k * int'(t1) - 32'sh1922);
      m_theta[2*k-1] = 17'(k * int'(t1));
      m_word[2*k-1]  = cosq(m_theta[2*k-2]);
      m_word[2*k]    = cosq(m_theta[2*k-1]);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_cyc  = 0;
      m_idx  = 0;
      hs_exp = 0;
    end else begin
      if (fe_valid && fe_ready) begin
        chk("hs_idx", int'(fe_idx), hs_exp);
        if (fe_idx < 3'(NW)) got[fe_idx] = int'($signed(fe_data));
        hs_cnt++;
        hs_exp = (hs_exp == NW - 1) ? 0 : hs_exp + 1;
      end
      if (!m_busy) begin
        if (x_valid) begin
          model_load(x_in);
          m_busy = 1'b1;
          m_cyc  = 0;
          m_idx  = 0;
        end
      end else begin
        if (m_cyc >= FIRST_OUT && fe_ready) begin
          if (m_idx == NW - 1) begin
            m_busy = 1'b0;
            m_idx  = 0;
          end else begin
            m_idx++;
          end
        end
        if (m_busy) m_cyc++;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset) begin : cmp
      bit e_issue, e_fev;
      int e_th, e_dat;
      e_issue = m_busy && m_cyc >= 1 && m_cyc <= 2 * ORDER;
      e_fev   = m_busy && m_cyc >= FIRST_OUT;
      e_th    = e_issue ? int'(m_theta[m_cyc-1]) : 0;
      e_dat   = e_fev ? int'(m_word[m_idx]) : 0;
      if (cu_issue) begin
        th_log[th_n % 256] = int'(cu_theta);
        th_n++;
      end
      chk("x_ready",  int'(x_ready),  int'(!m_busy));
      chk("busy",     int'(busy),     int'(m_busy));
      chk("cu_issue", int'(cu_issue), int'(e_issue));
      chk("cu_theta", int'(cu_theta), e_th);
      chk("fe_valid", int'(fe_valid), int'(e_fev));
      chk("fe_idx",   int'(fe_idx),   m_idx);
      chk("fe_last",  int'(fe_last),  int'(e_fev && m_idx == NW - 1));
      chk("fe_data",  int'($signed(fe_data)), e_dat);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x_ready"},  int'(x_ready),  1);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_cu_issue"}, int'(cu_issue), 0);
    chk({tag, "_cu_theta"}, int'(cu_theta), 0);
    chk({tag, "_fe_valid"}, int'(fe_valid), 0);
    chk({tag, "_fe_idx"},   int'(fe_idx),   0);
    chk({tag, "_fe_last"},  int'(fe_last),  0);
    chk({tag, "_fe_data"},  int'(fe_data),  0);
  endtask

  task automatic run_sample(input logic [15:0] x, output int lat, output int th_base);
    int n, hs0;
    hs0 = hs_cnt;
    @(negedge clk);
    th_base = th_n;
    x_in = x; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    lat = 0;
    while (!fe_valid && lat < 50) begin @(negedge clk); lat++; end
    n = 0;
    while (!x_ready && n < 50) begin @(negedge clk); n++; end
    chk("sample_done", int'(x_ready), 1);
    chk("sample_words", hs_cnt - hs0, NW);
  endtask

  int lat, tb0, d0, i0, hs0, n, n_bad;
  int p_half [NW];
  int exp_half_th [6] = '{'h00000, 'h01922, 'h01922, 'h03244, 'h03244, 'h04B66};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; x_in = '0; x_valid = 1'b0; fe_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;

    // x = 0: all sin ~ 0, all cos ~ +1, first word on cycle 9
    run_sample(16'h0000, lat, tb0);
    chk("first_valid_cycle", lat, 9);
    chk("x0_w0", got[0], 0);
    for (int k = 1; k <= ORDER; k++) begin
      chk_near("x0_sin", got[2*k-1], 0, 8);
      chk_near("x0_cos", got[2*k], 32767, 8);
    end

    // x = +0.5
    run_sample(16'h0800, lat, tb0);
    for (int i = 0; i < 6; i++) chk("half_theta", th_log[(tb0 + i) % 256], exp_half_th[i]);
    chk("half_w0", got[0], 'h0800);
    chk_near("half_sin1", got[1], 32767, 8);
    chk_near("half_cos1", got[2], 0, 8);
    chk_near("half_sin2", got[3], 0, 8);
    chk_near("half_cos2", got[4], -32768, 8);
    chk_near("half_sin3", got[5], -32768, 8);
    chk_near("half_cos3", got[6], 0, 8);
    for (int i = 0; i < NW; i++) p_half[i] = got[i];

    // x = -0.5: sin words negate, cos words match
    run_sample(16'hF800, lat, tb0);
    chk("nhalf_theta1", th_log[(tb0 + 1) % 256], 'h1E6DE);
    for (int k = 1; k <= ORDER; k++) begin
      chk_near("nhalf_sin", got[2*k-1], -p_half[2*k-1], 8);
      chk_near("nhalf_cos", got[2*k], p_half[2*k], 8);
    end

    // Backpressure at idx 3 with x_valid held high throughout
    hs0 = hs_cnt;
    @(negedge clk);
    x_in = 16'h0400; x_valid = 1'b1;
    n = 0;
    while (!(fe_valid && fe_idx == 3'd3) && n < 60) begin @(negedge clk); n++; end
    chk("bp_at_idx3", int'(fe_idx), 3);
    fe_ready = 1'b0;
    d0 = int'(fe_data); i0 = int'(fe_idx);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", int'(fe_data), d0);
      chk("bp_hold_idx", int'(fe_idx), i0);
      chk("bp_hold_valid", int'(fe_valid), 1);
    end
    fe_ready = 1'b1;
    n = 0;
    while (!x_ready && n < 60) begin @(negedge clk); n++; end
    chk("bp_ready_back", int'(x_ready), 1);
    chk("bp_words", hs_cnt - hs0, NW);
    @(negedge clk);
    x_valid = 1'b0;
    chk("bp_held_accept", int'(busy), 1);
    n = 0;
    while (!x_ready && n < 60) begin @(negedge clk); n++; end
    chk("bp_second_words", hs_cnt - hs0, 2 * NW);

    // Reset during the ISSUE phase aborts with no output
    @(negedge clk);
    x_in = 16'h0800; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_issue_active", int'(cu_issue), 1);
    #1 reset = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;
    n_bad = 0;
    repeat (15) begin @(negedge clk); if (fe_valid) n_bad++; end
    chk("midrst_no_output", n_bad, 0);
    chk("midrst_idle", int'(x_ready), 1);

    // Out-of-range input
    run_sample(16'h2000, lat, tb0);
`ifdef FLAF_X_SATURATE_EN
    chk("big_w0", got[0], 'h1000);
    chk("big_theta1", th_log[(tb0 + 1) % 256], 'h03244);
`else
    chk("big_w0", got[0], 'h2000);
    chk("big_theta1", th_log[(tb0 + 1) % 256], 'h06488);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
